// File: rtl/alu_mul_seq.sv
// ============================================================================
// Module      : alu_mul_seq
// Description : Sequential unsigned shift-and-add multiplier. It drives an
//               external combinational ALU with one add or shift-left per
//               clock and registers the ALU result. The product is the low N
//               bits of a*b, and ovf flags exactly when a*b exceeds 2^N-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product,
  output logic         ovf,
  output logic [N-1:0] alu_op1,
  output logic [N-1:0] alu_op2,
  output logic [3:0]   alu_cmd,
  input  logic [N-1:0] alu_out,
  input  logic         alu_over
);

  localparam logic [3:0]   C_CMD_ADD = 4'd0;
  localparam logic [3:0]   C_CMD_SHL = 4'd2;
  localparam logic [N-1:0] C_ONE     = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [N-1:0] r_acc;
  logic [N-1:0] r_mcand;
  logic [N-1:0] r_mplier;
  logic         r_lost;
  logic         r_ovf_acc;
  logic [N-1:0] r_product;
  logic         r_ovf;
  logic         w_ovf_upd;
  logic         w_last_add;

  // An ADD is the final step once no higher multiplier bits remain.
  assign w_last_add = (r_mplier[N-1:1] == '0);
  // A bit shifted out of the multiplicand is only reported when a later
  // add consumes it, which keeps the overflow flag exact.
  assign w_ovf_upd  = r_ovf_acc | alu_over | r_lost;

  assign product = r_product;
  assign ovf     = r_ovf;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and ALU drive.
  always_comb begin
    w_next  = r_state;
    alu_op1 = '0;
    alu_op2 = '0;
    alu_cmd = C_CMD_ADD;
    busy    = 1'b1;
    done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (b == '0) begin
            w_next = S_DONE;
          end else if (b[0]) begin
            w_next = S_ADD;
          end else begin
            w_next = S_SHIFT;
          end
        end
      end
      S_ADD: begin
        alu_op1 = r_acc;
        alu_op2 = r_mcand;
        alu_cmd = C_CMD_ADD;
        w_next  = w_last_add ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        alu_op1 = r_mcand;
        alu_op2 = C_ONE;
        alu_cmd = C_CMD_SHL;
        w_next  = r_mplier[1] ? S_ADD : S_SHIFT;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, accumulate/shift, result registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_lost    <= 1'b0;
      r_ovf_acc <= 1'b0;
      r_product <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc     <= '0;
            r_mcand   <= a;
            r_mplier  <= b;
            r_lost    <= 1'b0;
            r_ovf_acc <= 1'b0;
            if (b == '0) begin
              r_product <= '0;
              r_ovf     <= 1'b0;
            end
          end
        end
        S_ADD: begin
          r_acc     <= alu_out;
          r_ovf_acc <= w_ovf_upd;
          if (w_last_add) begin
            r_product <= alu_out;
            r_ovf     <= w_ovf_upd;
          end
        end
        S_SHIFT: begin
          r_mcand  <= alu_out;
          r_lost   <= r_lost | r_mcand[N-1];
          r_mplier <= r_mplier >> 1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/alu_mul_seq.md
# alu_mul_seq

Sequential unsigned multiplier controller that sits directly upstream of the combinational `ALU` (N-bit add/sub/shift/compare unit) and drives it. The block implements shift-and-add multiplication by issuing ALU add (`cmd=4'd0`) and shift-left (`cmd=4'd2`) operations one per clock and registering the ALU result each cycle. The product is truncated to N bits, with an exact overflow flag. It replaces the testbench-only repeated-addition task with synthesizable hardware, giving bounded latency.

## Interface
- `N`, 8, operand/product width; must match the attached ALU's `N`.

- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `a`  in  N  multiplicand, captured when start is accepted
- `b`  in  N  multiplier, captured when start is accepted
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse; product/ovf valid
- `product`  out  N  registered result, low N bits of a*b; held until next done
- `ovf`  out  1  registered; 1 iff a*b > 2^N-1; held with product
- `alu_op1`  out  N  to ALU op1
- `alu_op2`  out  N  to ALU op2
- `alu_cmd`  out  4  to ALU cmd
- `alu_out`  in  N  from ALU out (combinational, same cycle)
- `alu_over`  in  1  from ALU over

## Operation
- Internal regs: `acc`[N], `mcand`[N], `mplier`[N], `lost` (sticky), state ∈ {IDLE, ADD, SHIFT, DONE}.
- Reset (async, rst_n=0): state=IDLE; acc, mcand, mplier, lost, product, ovf = 0; busy=0, done=0.
- IDLE: ALU drive op1=0, op2=0, cmd=0. If start=1: acc←0, mcand←a, mplier←b, lost←0, ovf accumulator←0. Next state: b==0 → DONE; b[0]=1 → ADD; otherwise → SHIFT.
- ADD: drive op1=acc, op2=mcand, cmd=4'd0. acc←alu_out; ovf accumulator |= alu_over | lost. Next: mplier[N-1:1]==0 → DONE, else SHIFT.
- SHIFT: drive op1=mcand, op2=1, cmd=4'd2. mcand←alu_out; lost |= mcand[N-1] (pre-shift); mplier←mplier>>1 (internal, not via ALU). Next: mplier[1]=1 → ADD, else SHIFT.
- SHIFT is only entered while higher multiplier bits are nonzero, so every lost bit is followed by an ADD. This makes ovf exact.
- Transition into DONE: product←acc value as updated on that edge, and ovf←accumulated flag. For b==0, product←0 and ovf←0.
- DONE: done=1 and busy=1 for exactly one cycle; ALU drive as in IDLE. Next state is IDLE unconditionally.
- start is ignored while busy. A start held high through DONE is accepted on the first IDLE cycle.
- All arithmetic is unsigned, N bits. The shift amount is always 1.

## Timing
- Let E0 be the edge at which start is accepted. Let k = popcount(b) + (index of highest set bit of b), with k=0 for b=0.
- DONE occupies the cycle after edge E0+k. done is high from E0+k to E0+k+1; busy falls at E0+k+1.
- Range for N=8: k ∈ [0, 15]; b=0xFF gives k=15.
- ALU outputs are used in the same cycle they are driven; there are no multicycle paths.
- product and ovf change only on entry to DONE (or on reset). They are stable in every other cycle, including during a new operation.
- Reset asserted mid-operation aborts immediately to IDLE. done does not pulse; product=0, ovf=0.

## Test plan
- a=3, b=5 → state sequence ADD, SHIFT, SHIFT, ADD, DONE. done at E0+4, product=15, ovf=0, busy high for 5 cycles.
- a=0x10, b=0x10 → done at E0+5, product=0x00, ovf=1 (lost-bit path).
- a=20, b=13 → product=4 (260 mod 256), ovf=1 via alu_over. Also a=0x80, b=2 → product=0, ovf=1.
- a=0xFF, b=0 → done at E0 (DONE in the first cycle), product=0, ovf=0. Then a=0xFF, b=1 → k=1, product=0xFF, ovf=0.
- Pulse start with a=9, b=9 during busy of a prior 3×5 operation → ignored; 3×5 result (15) is unaffected and busy timing is unchanged.
- Drop rst_n low at E0+2 of a=7, b=0xFF → busy=0, done never pulses, product=0, ovf=0. After release, a new start 2×3 → product=6.
